// File: rtl/shift_accumulator.sv
// Frame accumulator for the log-quantised MAC datapath: bias + N_TERMS shifted products -> saturated result.
// Optional macro SHIFT_ACC_RELU_EN clamps negative results to zero before they reach o_result.
module shift_accumulator #(
    parameter int N_TERMS = 16,
    parameter int ACC_W   = 40,
    parameter int OUT_W   = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_start,
    input  logic [31:0]      i_bias,
    input  logic             i_skip,
    input  logic [31:0]      i_bit_shifted,
    output logic [OUT_W-1:0] o_result,
    output logic             o_valid,
    output logic             o_busy,
    output logic             o_overflow
);

    localparam int CNT_W = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_TERMS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [ACC_W-1:0]   acc_reg, acc_next;
    logic [CNT_W-1:0]   count_reg, count_next;
    logic [OUT_W-1:0]   result_reg;
    logic               valid_reg;
    logic               busy_reg;
    logic               overflow_reg;

    logic [ACC_W-1:0]   bias_ext;
    logic [ACC_W-1:0]   term_ext;
    logic [ACC_W-OUT_W:0] acc_top;
    logic               sat_pos;
    logic               sat_neg;
    logic [OUT_W-1:0]   sat_value;
    logic [OUT_W-1:0]   result_value;

    assign bias_ext = {{(ACC_W-32){i_bias[31]}}, i_bias};
    assign term_ext = {{(ACC_W-32){i_bit_shifted[31]}}, i_bit_shifted};

    // The value fits in OUT_W bits only when every bit above the OUT_W sign bit matches it.
    assign acc_top   = acc_reg[ACC_W-1:OUT_W-1];
    assign sat_pos   = ~acc_reg[ACC_W-1] & (|acc_top);
    assign sat_neg   = acc_reg[ACC_W-1] & ~(&acc_top);
    assign sat_value = sat_pos ? {1'b0, {(OUT_W-1){1'b1}}} :
                       sat_neg ? {1'b1, {(OUT_W-1){1'b0}}} :
                                 acc_reg[OUT_W-1:0];

`ifdef SHIFT_ACC_RELU_EN
    assign result_value = sat_value[OUT_W-1] ? '0 : sat_value;
`else
    assign result_value = sat_value;
`endif

    always_comb begin
        state_next = state_reg;
        acc_next   = acc_reg;
        count_next = count_reg;
        case (state_reg)
            ST_IDLE: begin
                if (i_start) begin
                    acc_next   = bias_ext;
                    count_next = '0;
                    state_next = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                // Skipped cycles carry no product and do not advance the term count.
                if (!i_skip) begin
                    acc_next   = acc_reg + term_ext;
                    count_next = count_reg + CNT_W'(1);
                    if (count_reg == LAST_IDX) begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= ST_IDLE;
            acc_reg      <= '0;
            count_reg    <= '0;
            result_reg   <= '0;
            valid_reg    <= 1'b0;
            busy_reg     <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            count_reg <= count_next;
            valid_reg <= (state_reg == ST_DONE);
            busy_reg  <= (state_next != ST_IDLE);
            if (state_reg == ST_DONE) begin
                result_reg   <= result_value;
                overflow_reg <= sat_pos | sat_neg;
            end
        end
    end

    assign o_result   = result_reg;
    assign o_valid    = valid_reg;
    assign o_busy     = busy_reg;
    assign o_overflow = overflow_reg;

endmodule

// File: doc/shift_accumulator.md
Name: shift_accumulator

Overview:
- Downstream consumer of the bit_shifter stage in the log-quantised MAC datapath.
- Sums a frame of N_TERMS signed 32-bit shifted partial products, plus a preloaded bias, into a wide accumulator.
- Honours the upstream skip flag: a skipped cycle carries no new product and is not counted.
- Emits a saturated OUT_W-bit result with a one-cycle valid pulse and a sticky overflow flag.

Parameters:
- N_TERMS, 16: non-skipped products per frame; must be ≥ 1.
- ACC_W, 40: internal accumulator width; must be ≥ OUT_W + clog2(N_TERMS) + 1.
- OUT_W, 32: width of o_result; signed, two's complement.

Ports:
- clk  in  1: rising-edge clock.
- reset_n  in  1: asynchronous active-low reset.
- i_start  in  1: begin a new frame and load i_bias; honoured only in IDLE.
- i_bias  in  32: signed bias, sampled with an accepted i_start.
- i_skip  in  1: connects to upstream o_skip; 1 = no product this cycle.
- i_bit_shifted  in  32: connects to upstream o_bit_shifted; signed two's complement product.
- o_result  out  OUT_W: saturated frame sum (after ReLU when enabled).
- o_valid  out  1: one-cycle pulse when o_result updates.
- o_busy  out  1: high while in ACCUM or DONE.
- o_overflow  out  1: saturation occurred for the frame currently on o_result.

Behaviour:
- Reset (async, reset_n low):
  - state = IDLE; acc = 0; count = 0.
  - o_result = 0, o_valid = 0, o_busy = 0, o_overflow = 0.
  - Reset asserted mid-frame discards the frame and produces no o_valid.
- FSM states: IDLE, ACCUM, DONE.
- IDLE:
  - i_start=1 → acc ← sign-extended i_bias, count ← 0, next state ACCUM.
  - i_skip and i_bit_shifted are ignored.
- ACCUM:
  - i_skip=0 → acc ← acc + sext(i_bit_shifted), count ← count + 1.
  - i_skip=1 → acc and count hold; i_bit_shifted is don't-care.
  - Accepting the term with count == N_TERMS-1 → next state DONE.
  - i_start is ignored in ACCUM.
- DONE (exactly one cycle):
  - o_result ← sat(acc); o_overflow ← (sat was applied); o_valid ← 1.
  - Next state IDLE. i_start and terms are ignored.
- Latency:
  - Last term is accepted at edge k; o_valid is high during the cycle after edge k+1, for exactly one cycle.
  - o_busy is a registered function of state: high during ACCUM and DONE, low in IDLE.
- Output hold: o_result and o_overflow hold until the next o_valid pulse; o_valid is 0 otherwise.
- Back-to-back: i_start sampled in the cycle o_valid is high is accepted, since state is already IDLE. Minimum frame period is N_TERMS + 2 cycles.
- Saturation:
  - acc > 2^(OUT_W-1)-1 → o_result = 2^(OUT_W-1)-1.
  - acc < -2^(OUT_W-1) → o_result = -2^(OUT_W-1).
  - Otherwise o_result = acc truncated to OUT_W bits.
- Arithmetic: all signed. A negative zero from upstream arrives as 32'h0 and adds 0; no special case.

Optional Feature:
- Macro: SHIFT_ACC_RELU_EN.
- Defined: in DONE, a negative saturated value is replaced by 0 before loading o_result. o_overflow still reflects saturation only.
- Undefined: o_result is the signed saturated sum; no ReLU logic is synthesised.

Test Plan:
- Basic sum (N_TERMS=4, bias 0):
  - Stimulus: start, then terms 8, 16, 32'hFFFFFFFC (-4), 128, i_skip=0.
  - Required: o_result=148, o_overflow=0, o_valid one cycle, 2 cycles after the last term; o_busy low afterwards.
- Skip interleave:
  - Stimulus: same frame with i_skip=1 cycles carrying i_bit_shifted=1000 between terms.
  - Required: o_result=148; o_busy stays high throughout; count advances only on i_skip=0.
- Saturation (N_TERMS=4):
  - Positive: bias 32'h7FFFFFF0, 4× 16320 → o_result=32'h7FFFFFFF, o_overflow=1.
  - Negative: bias 32'h80000000, 4× -16320 → o_result=32'h80000000, o_overflow=1.
- Start handling (N_TERMS=4):
  - i_start pulsed during ACCUM → ignored; result is unchanged and timing is unchanged.
  - i_start in the o_valid cycle with bias 5, terms 1,1,1,1 → second o_valid with o_result=9 exactly 6 cycles after the start.
- Reset mid-frame:
  - Stimulus: reset_n low after 2 accepted terms, then released.
  - Required: all outputs 0 immediately (asynchronously), no o_valid, state IDLE; a fresh frame then works normally.
- ReLU (bias -100, terms all 0):
  - With SHIFT_ACC_RELU_EN: o_result=0.
  - Without: o_result=32'hFFFFFF9C.
  - o_overflow=0 in both cases.
